// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - two-stage sprite priority/palette compositor with per-frame collision flags
// Optional macro SPRITE_COMP_PAL_WRITE_EN: writable palette registers (else constant reset table).
module sprite_compositor #(
  parameter int               NSPR      = 2,
  parameter int               SPR_DATAW = 2,
  parameter int               COLRW     = 12,
  parameter logic [COLRW-1:0] BG_COLR   = 12'h4AF,
  parameter logic [COLRW-1:0] PAL_RST_1 = 12'hFF0,
  parameter logic [COLRW-1:0] PAL_RST_2 = 12'hF80,
  parameter logic [COLRW-1:0] PAL_RST_3 = 12'h000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bright,
  input  logic                            frame,
  input  logic [NSPR*SPR_DATAW-1:0]       pix,
  input  logic [NSPR-1:0]                 drawing,
  input  logic                            pal_we,
  input  logic [$clog2(NSPR)+SPR_DATAW-1:0] pal_addr,
  input  logic [COLRW-1:0]                pal_wdata,
  output logic [COLRW-1:0]                rgb,
  output logic                            bright_o,
  output logic [NSPR-1:0]                 collide,
  output logic                            collide_valid
);

  localparam int IDW  = $clog2(NSPR);
  localparam int NENT = 2 ** SPR_DATAW;
  localparam int NPAL = NSPR * NENT;

  function automatic logic [COLRW-1:0] pal_rst_val(input int unsigned ent);
    case (ent)
      1:       return PAL_RST_1;
      2:       return PAL_RST_2;
      3:       return PAL_RST_3;
      default: return '0;
    endcase
  endfunction

  logic [NSPR-1:0]      opaque;
  logic [IDW-1:0]       win_id_d, win_id_q;
  logic [SPR_DATAW-1:0] win_pix_d, win_pix_q;
  logic                 any_opaque_d, any_opaque_q;
  logic                 bright_s1_d, bright_s1_q;
  logic [COLRW-1:0]     rgb_d, rgb_q;
  logic                 bright_o_d, bright_o_q;
  logic [NSPR-1:0]      acc_d, acc_q;
  logic [NSPR-1:0]      collide_d, collide_q;
  logic                 collide_valid_d, collide_valid_q;
  logic                 multi_opaque;
  logic [COLRW-1:0]     pal [NPAL];

  // Scan from the highest index down so the lowest-index opaque sprite wins.
  always_comb begin
    opaque    = '0;
    win_id_d  = '0;
    win_pix_d = '0;
    for (int i = NSPR - 1; i >= 0; i--) begin
      opaque[i] = drawing[i] && (pix[i*SPR_DATAW +: SPR_DATAW] != '0);
      if (opaque[i]) begin
        win_id_d  = IDW'(i);
        win_pix_d = pix[i*SPR_DATAW +: SPR_DATAW];
      end
    end
    any_opaque_d = |opaque;
    bright_s1_d  = bright;
  end

`ifdef SPRITE_COMP_PAL_WRITE_EN
  logic [COLRW-1:0] pal_q [NPAL];
  logic [COLRW-1:0] pal_d [NPAL];

  always_comb begin
    pal_d = pal_q;
    if (pal_we && (32'(pal_addr >> SPR_DATAW) < NSPR))
      pal_d[pal_addr] = pal_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NPAL; e++)
        pal_q[e] <= pal_rst_val(e % NENT);
    end else begin
      pal_q <= pal_d;
    end
  end

  assign pal = pal_q;
`else
  logic unused_pal;

  always_comb begin
    for (int e = 0; e < NPAL; e++)
      pal[e] = pal_rst_val(e % NENT);
  end

  assign unused_pal = ^{pal_we, pal_addr, pal_wdata};
`endif

  // Lookup reads the current palette, so a same-cycle write is seen one pixel later.
  always_comb begin
    rgb_d      = !bright_s1_q ? '0 : any_opaque_q ? pal[{win_id_q, win_pix_q}] : BG_COLR;
    bright_o_d = bright_s1_q;
  end

  always_comb begin
    multi_opaque    = |(opaque & (opaque - NSPR'(1)));
    acc_d           = acc_q;
    collide_d       = collide_q;
    collide_valid_d = frame;
    if (frame) begin
      collide_d = acc_q;
      acc_d     = '0;
    end else if (bright && multi_opaque) begin
      acc_d = acc_q | opaque;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_id_q        <= '0;
      win_pix_q       <= '0;
      any_opaque_q    <= 1'b0;
      bright_s1_q     <= 1'b0;
      rgb_q           <= '0;
      bright_o_q      <= 1'b0;
      acc_q           <= '0;
      collide_q       <= '0;
      collide_valid_q <= 1'b0;
    end else begin
      win_id_q        <= win_id_d;
      win_pix_q       <= win_pix_d;
      any_opaque_q    <= any_opaque_d;
      bright_s1_q     <= bright_s1_d;
      rgb_q           <= rgb_d;
      bright_o_q      <= bright_o_d;
      acc_q           <= acc_d;
      collide_q       <= collide_d;
      collide_valid_q <= collide_valid_d;
    end
  end

  assign rgb           = rgb_q;
  assign bright_o      = bright_o_q;
  assign collide       = collide_q;
  assign collide_valid = collide_valid_q;

endmodule
